search_table_loader: RTL and testbench



---
 rtl/search_pkg.sv | 13 +
 rtl/search_table_ram.sv | 31 +++
 rtl/search_table_loader.sv | 134 +++++++++++++
 tb/tb_search_table_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/search_pkg.sv
// Shared definitions for the linear-search key table and its control unit.
package search_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } search_state_e;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 5;
  localparam int ADDR_W_DEF = 3;
endpackage

// File: rtl/search_table_ram.sv
// Key table storage: one write port, registered read address, storage not reset.
module search_table_ram #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 5,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_addr_reg <= '0;
    else        rd_addr_reg <= rd_addr;
  end

  // Addresses past the last entry read as zero rather than aliasing.
  assign rd_data = ({1'b0, rd_addr_reg} < DEPTH_W) ? mem[rd_addr_reg] : '0;
endmodule

// File: rtl/search_table_loader.sv
// Write side of the search key table: clears the table, then loads a burst of words.
module search_table_loader
  import search_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              table_valid,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  search_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg, overflow_next;
  logic              table_valid_reg, table_valid_next;
  logic              in_ready_reg, in_ready_next;
  logic              last_seen_reg, last_seen_next;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      clr_ptr_reg     <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      table_valid_reg <= 1'b0;
      in_ready_reg    <= 1'b0;
      last_seen_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clr_ptr_reg     <= clr_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      count_reg       <= count_next;
      overflow_reg    <= overflow_next;
      table_valid_reg <= table_valid_next;
      in_ready_reg    <= in_ready_next;
      last_seen_reg   <= last_seen_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_ptr_next   = clr_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    last_seen_next = last_seen_reg;
    we             = 1'b0;
    waddr          = clr_ptr_reg;
    wdata          = '0;

    // A restart from any state wins over everything else, including a handshake.
    if (load_start) begin
      state_next     = CLEAR;
      clr_ptr_next   = '0;
      wr_ptr_next    = '0;
      count_next     = '0;
      overflow_next  = 1'b0;
      last_seen_next = 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          we = 1'b1;
          if (clr_ptr_reg == LAST_ADDR) begin
            state_next  = LOAD;
            wr_ptr_next = '0;
          end else begin
            clr_ptr_next = clr_ptr_reg + 1'b1;
          end
        end
        LOAD: begin
          if (in_valid && in_ready_reg) begin
            we         = 1'b1;
            waddr      = wr_ptr_reg;
            wdata      = in_data;
            count_next = count_reg + 1'b1;
            if (wr_ptr_reg != LAST_ADDR) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (in_last || (count_reg == FULL - 1'b1)) begin
              state_next     = DONE;
              last_seen_next = in_last;
            end
          end
        end
        DONE: begin
          // Only a table filled without in_last treats further words as overflow.
          if (in_valid && !last_seen_reg) overflow_next = 1'b1;
        end
        default: ;
      endcase
    end

    table_valid_next = (state_next == DONE);
    in_ready_next    = (state_reg == LOAD) && (state_next == LOAD) && (count_next < FULL);
  end

  search_table_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign in_ready    = in_ready_reg;
  assign busy        = (state_reg == CLEAR) || (state_reg == LOAD);
  assign table_valid = table_valid_reg;
  assign count       = count_reg;
  assign overflow    = overflow_reg;
endmodule

// File: tb/tb_search_table_loader.sv
// Randomized and directed checks of search_table_loader against a table-level model.
module tb_search_table_loader;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 5;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              busy;
  logic              table_valid;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;

  search_table_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .busy        (busy),
    .table_valid (table_valid),
    .count       (count),
    .overflow    (overflow),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: table contents, entries written, how the load ended.
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                model_count;
  bit                model_last;
  bit                model_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input bit hold_valid, input logic [DATA_W-1:0] hold_data);
    load_start = 1'b1;
    in_valid   = hold_valid;
    in_data    = hold_data;
    in_last    = 1'b0;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_count = 0;
    model_last  = 1'b0;
    model_ovf   = 1'b0;
    check_eq("busy_clear", busy, 1);
    check_eq("count_clear", count, 0);
    check_eq("tv_clear", table_valid, 0);
    check_eq("ovf_clear", overflow, 0);
    check_eq("ready_early", in_ready, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      check_eq("ready_early", in_ready, 0);
    end
    tick();
    check_eq("ready_first", in_ready, 1);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input bit last, input int gap);
    int  budget;
    bit  terminal;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    in_data  = w;
    in_valid = 1'b1;
    in_last  = last;
    budget   = 50;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!in_ready) begin
      check_eq("ready_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_mem[model_count] = w;
    model_count++;
    terminal = last || (model_count == DEPTH);
    if (terminal) model_last = last;
    check_eq("count", count, model_count);
    check_eq("table_valid", table_valid, terminal);
    check_eq("ready_after", in_ready, !terminal);
    check_eq("busy_after", busy, !terminal);
  endtask

  task automatic read_all(input string tag);
    logic [31:0] exp;
    for (int a = 0; a < 8; a++) begin
      rd_addr = ADDR_W'(a);
      tick();
      exp = (a < DEPTH) ? 32'(model_mem[a]) : 32'd0;
      check_eq(tag, rd_data, exp);
    end
  endtask

  task automatic offer_extra(input logic [DATA_W-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("ready_done", in_ready, 0);
    end
    in_valid = 1'b0;
    if (model_count == DEPTH && !model_last) model_ovf = 1'b1;
    check_eq("overflow", overflow, model_ovf);
    check_eq("count_hold", count, model_count);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    int len;
    bit use_last;

    // Reset state
    repeat (2) tick();
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tv", table_valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_ovf", overflow, 0);
    reset = 1'b1;
    tick();
    check_eq("idle_busy", busy, 0);

    // Basic load 3,7,1,9,2 with in_last on the fifth word
    $display("txn: load 3,7,1,9,2");
    start_load(1'b0, '0);
    send_word(4'h3, 0, 0);
    send_word(4'h7, 0, 1);
    send_word(4'h1, 0, 0);
    send_word(4'h9, 0, 2);
    send_word(4'h2, 1, 0);
    read_all("rd_basic");
    offer_extra(4'hF);

    // Short load over a full table: tail entries must be cleared
    $display("txn: load 6,4 over full table");
    start_load(1'b0, '0);
    send_word(4'h6, 0, 0);
    send_word(4'h4, 1, 0);
    read_all("rd_short");
    offer_extra(4'hF);

    // Fill without in_last, then offer one more word
    $display("txn: fill without last, then overflow");
    start_load(1'b0, '0);
    for (int i = 0; i < DEPTH; i++) send_word(4'($urandom_range(1, 14)), 0, 0);
    offer_extra(4'hF);
    read_all("rd_ovf");
    check_eq("ovf_sticky", overflow, 1);

    // Restart mid-load while a word is offered
    $display("txn: restart during load");
    start_load(1'b0, '0);
    send_word(4'hA, 0, 0);
    send_word(4'hB, 0, 0);
    in_data    = 4'hD;
    in_valid   = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    in_valid   = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_count = 0;
    check_eq("rs_count", count, 0);
    check_eq("rs_ready", in_ready, 0);
    check_eq("rs_busy", busy, 1);
    repeat (DEPTH + 1) tick();
    check_eq("rs_ready_back", in_ready, 1);
    read_all("rd_restart");

    // in_valid held through CLEAR: first word must land at address 0
    $display("txn: valid held through clear");
    start_load(1'b1, 4'hC);
    send_word(4'hC, 0, 0);
    send_word(4'h5, 1, 0);
    read_all("rd_hold");

    // Randomized loads
    for (int r = 0; r < 20; r++) begin
      len      = $urandom_range(1, DEPTH);
      use_last = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      $display("txn: random round %0d len %0d last %0d", r, len, use_last);
      start_load(1'($urandom_range(0, 1)), 4'($urandom));
      for (int i = 0; i < len; i++) begin
        w = 4'($urandom);
        send_word(w, use_last && (i == len - 1), $urandom_range(0, 2));
      end
      read_all("rd_rand");
      offer_extra(4'($urandom));
    end

    // Reset in the middle of a load
    $display("txn: reset mid-load");
    start_load(1'b0, '0);
    send_word(4'h8, 0, 0);
    send_word(4'h2, 0, 0);
    reset = 1'b0;
    #1;
    check_eq("mr_ready", in_ready, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_tv", table_valid, 0);
    check_eq("mr_count", count, 0);
    check_eq("mr_ovf", overflow, 0);
    tick();
    reset = 1'b1;
    in_data  = 4'h7;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check_eq("mr_idle_busy", busy, 0);
    check_eq("mr_idle_ready", in_ready, 0);
    check_eq("mr_idle_count", count, 0);
    check_eq("mr_idle_tv", table_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
